// File: rtl/muldiv_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
interface muldiv_if;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  stall_req, done, hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output stall_req, done, hi_we, lo_we, hi_wdata, lo_wdata
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: 32 shift-add or restoring-divide
// steps on operand magnitudes, then a sign fix-up into the HI/LO result registers.
module muldiv_unit (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        signed_op;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum, div_shift, div_trial;
    logic [63:0] iter_acc, prod;
    logic [31:0] quo, rem;

    always_comb begin
        signed_op = ~bus.op[0];
        abs_a = (signed_op && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
        abs_b = (signed_op && bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;

        // acc holds {upper, lower}: product/multiplier for MUL, remainder/dividend-quotient for DIV
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (is_div_q)
            iter_acc = div_trial[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                     : {div_trial[31:0], acc_q[30:0], 1'b1};
        else
            iter_acc = {mul_sum, acc_q[31:1]};

        prod = neg_res_q ? (~iter_acc + 64'd1) : iter_acc;
        quo  = div0_q ? 32'hFFFF_FFFF
                      : (neg_res_q ? (~iter_acc[31:0] + 32'd1) : iter_acc[31:0]);
        rem  = neg_rem_q ? (~iter_acc[63:32] + 32'd1) : iter_acc[63:32];

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.op_valid && !bus.flush) begin
                    state_d   = BUSY;
                    cnt_d     = 6'd0;
                    is_div_d  = bus.op[1];
                    opnd_d    = bus.op[1] ? abs_b : abs_a;
                    acc_d     = {32'd0, bus.op[1] ? abs_a : abs_b};
                    neg_res_d = signed_op && (bus.src_a[31] ^ bus.src_b[31]);
                    neg_rem_d = signed_op && bus.op[1] && bus.src_a[31];
                    div0_d    = bus.op[1] && (bus.src_b == 32'd0);
                end
            end
            BUSY: begin
                acc_d = iter_acc;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                    // With a zero divisor the remainder magnitude is |a|, so the
                    // dividend-sign fix-up returns src_a unchanged.
                    hi_d = is_div_q ? rem : prod[63:32];
                    lo_d = is_div_q ? quo : prod[31:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.stall_req = (state_q == IDLE && bus.op_valid && !bus.flush) || (state_q == BUSY);
    assign bus.done      = (state_q == DONE) && !bus.flush;
    assign bus.hi_we     = bus.done;
    assign bus.lo_we     = bus.done;
    assign bus.hi_wdata  = hi_q;
    assign bus.lo_wdata  = lo_q;
endmodule
